// File: rtl/addsub_pipe.sv
// Pipelined multi-lane adder/subtractor. The carry chain is cut into SEG-bit
// segments with one register stage each; the last stage also saturates.
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  parameter int SEG   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [WIDTH*LANES-1:0] in_a,
  input  logic [WIDTH*LANES-1:0] in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] out_result,
  output logic [LANES-1:0]       out_carry,
  output logic [LANES-1:0]       out_ovf
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LW     = WIDTH * LANES;

  logic             adv;
  logic [LW-1:0]    bx;
  logic             out_valid_q;
  logic [LW-1:0]    out_result_q, res_d;
  logic [LANES-1:0] out_carry_q, out_ovf_q, ovf_d;

  always_comb begin
    adv = !out_valid_q || out_ready;
    bx  = in_b ^ {LW{in_op[0]}};
  end

  // Intermediate stages carry only the still-unresolved operand bits, so each
  // stage has its own widths and reads the previous stage by hierarchical name.
  for (genvar s = 0; s < STAGES - 1; s++) begin : g_stg
    localparam int DONE = (s + 1) * SEG;
    localparam int REM  = WIDTH - DONE;

    logic                       vld_q, vld_d, sat_q, sat_d;
    logic [LANES-1:0][DONE-1:0] sum_q, sum_d;
    logic [LANES-1:0][REM-1:0]  ra_q, ra_d, rb_q, rb_d;
    logic [LANES-1:0]           cy_q, cy_d, sa_q, sa_d, sb_q, sb_d;
    logic [SEG:0]               t;

    if (s == 0) begin : g_head
      always_comb begin
        vld_d = in_valid;
        sat_d = in_op[1];
        t     = '0;
        sum_d = '0;
        cy_d  = '0;
        ra_d  = '0;
        rb_d  = '0;
        sa_d  = '0;
        sb_d  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
          t        = {1'b0, in_a[l*WIDTH +: SEG]} + {1'b0, bx[l*WIDTH +: SEG]}
                   + (SEG+1)'(in_op[0]);
          cy_d[l]  = t[SEG];
          sum_d[l] = t[SEG-1:0];
          ra_d[l]  = in_a[l*WIDTH+SEG +: REM];
          rb_d[l]  = bx[l*WIDTH+SEG +: REM];
          sa_d[l]  = in_a[l*WIDTH+WIDTH-1];
          sb_d[l]  = bx[l*WIDTH+WIDTH-1];
        end
      end
    end else begin : g_body
      always_comb begin
        vld_d = g_stg[s-1].vld_q;
        sat_d = g_stg[s-1].sat_q;
        sa_d  = g_stg[s-1].sa_q;
        sb_d  = g_stg[s-1].sb_q;
        t     = '0;
        sum_d = '0;
        cy_d  = '0;
        ra_d  = '0;
        rb_d  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
          t        = {1'b0, g_stg[s-1].ra_q[l][SEG-1:0]} + {1'b0, g_stg[s-1].rb_q[l][SEG-1:0]}
                   + (SEG+1)'(g_stg[s-1].cy_q[l]);
          cy_d[l]  = t[SEG];
          sum_d[l] = {t[SEG-1:0], g_stg[s-1].sum_q[l]};
          ra_d[l]  = g_stg[s-1].ra_q[l][REM+SEG-1:SEG];
          rb_d[l]  = g_stg[s-1].rb_q[l][REM+SEG-1:SEG];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sat_q <= 1'b0;
        sum_q <= '0;
        cy_q  <= '0;
        ra_q  <= '0;
        rb_q  <= '0;
        sa_q  <= '0;
        sb_q  <= '0;
      end else if (adv) begin
        vld_q <= vld_d;
        sat_q <= sat_d;
        sum_q <= sum_d;
        cy_q  <= cy_d;
        ra_q  <= ra_d;
        rb_q  <= rb_d;
        sa_q  <= sa_d;
        sb_q  <= sb_d;
      end
    end
  end

  logic                        fin_vld, fin_sat;
  logic [LANES-1:0][WIDTH-1:0] fin_sum;
  logic [LANES-1:0]            fin_cy, fin_sa, fin_sb;

  // The top segment is resolved in the output stage itself.
  if (STAGES == 1) begin : g_fin_in
    logic [WIDTH:0] t;
    always_comb begin
      fin_vld = in_valid;
      fin_sat = in_op[1];
      t       = '0;
      fin_sum = '0;
      fin_cy  = '0;
      fin_sa  = '0;
      fin_sb  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        t          = {1'b0, in_a[l*WIDTH +: WIDTH]} + {1'b0, bx[l*WIDTH +: WIDTH]}
                   + (WIDTH+1)'(in_op[0]);
        fin_cy[l]  = t[WIDTH];
        fin_sum[l] = t[WIDTH-1:0];
        fin_sa[l]  = in_a[l*WIDTH+WIDTH-1];
        fin_sb[l]  = bx[l*WIDTH+WIDTH-1];
      end
    end
  end else begin : g_fin_in
    logic [SEG:0] t;
    always_comb begin
      fin_vld = g_stg[STAGES-2].vld_q;
      fin_sat = g_stg[STAGES-2].sat_q;
      fin_sa  = g_stg[STAGES-2].sa_q;
      fin_sb  = g_stg[STAGES-2].sb_q;
      t       = '0;
      fin_sum = '0;
      fin_cy  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
        t          = {1'b0, g_stg[STAGES-2].ra_q[l]} + {1'b0, g_stg[STAGES-2].rb_q[l]}
                   + (SEG+1)'(g_stg[STAGES-2].cy_q[l]);
        fin_cy[l]  = t[SEG];
        fin_sum[l] = {t[SEG-1:0], g_stg[STAGES-2].sum_q[l]};
      end
    end
  end

  always_comb begin
    res_d = '0;
    ovf_d = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      ovf_d[l] = (fin_sa[l] == fin_sb[l]) && (fin_sum[l][WIDTH-1] != fin_sa[l]);
      if (fin_sat && ovf_d[l])
        res_d[l*WIDTH +: WIDTH] = fin_sa[l] ? {1'b1, {(WIDTH-1){1'b0}}}
                                            : {1'b0, {(WIDTH-1){1'b1}}};
      else
        res_d[l*WIDTH +: WIDTH] = fin_sum[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_carry_q  <= '0;
      out_ovf_q    <= '0;
    end else if (adv) begin
      out_valid_q  <= fin_vld;
      out_result_q <= res_d;
      out_carry_q  <= fin_cy;
      out_ovf_q    <= ovf_d;
    end
  end

  assign in_ready   = adv;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_ovf    = out_ovf_q;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined, multi-lane adder/subtractor for the matrix coprocessor datapath. It adds or subtracts LANES packed elements per transfer.
- The carry chain is split into SEG-bit segments, with one register stage per segment, so wide elements meet timing.
- Supports wrap-around and signed-saturating modes and reports per-lane carry and overflow.
- Sits between the operand fetch and the result writeback of the matrix add/sub instructions, using a valid/ready handshake on both sides.

Parameters:
- WIDTH, 8, element width in bits; must be a multiple of SEG.
- LANES, 4, number of independent elements per transfer.
- SEG, 4, bits resolved per pipeline stage. STAGES = WIDTH/SEG, which is also the latency.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand transfer valid.
- in_ready  output  1  block can accept a transfer this cycle.
- in_op  input  2  operation: 00 add, 01 sub, 10 signed saturating add, 11 signed saturating sub.
- in_a  input  WIDTH*LANES  operand A, lane i at bits [i*WIDTH +: WIDTH].
- in_b  input  WIDTH*LANES  operand B, same packing.
- out_valid  output  1  result transfer valid.
- out_ready  input  1  downstream accepts result.
- out_result  output  WIDTH*LANES  per-lane result.
- out_carry  output  LANES  per-lane carry-out; for sub, 1 = no borrow.
- out_ovf  output  LANES  per-lane signed overflow, pre-saturation.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: every stage valid bit, out_valid, out_result, out_carry and out_ovf clear to 0 immediately on rst_n low.
- Reset mid-operation: all in-flight transfers are discarded and no partial result appears. After release, the first accepted transfer emerges STAGES cycles later.
- Advance enable: adv = !out_valid || out_ready. All stages shift together when adv=1 and hold otherwise. Bubbles are not collapsed.
- in_ready = adv, a combinational function of out_valid and out_ready. A transfer is accepted when in_valid && in_ready.
- Stage 0 on accept:
  - b' = in_b when op[0]=0, else ~in_b; cin = op[0].
  - Register the low SEG bits of a + b' + cin per lane, the segment carry, the remaining upper operand bits, the op, the sign bits a[MSB] and b'[MSB], and valid.
- Stage k (1..STAGES-1): add segment k of each lane with the carry registered from stage k-1, then register the result and carry.
- Carry rule: the carry never crosses lane boundaries. Each lane has its own chain seeded with cin.
- Final results, per lane:
  - carry = carry out of the top segment.
  - ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]).
  - op[1]=0: result = raw sum (wrap-around).
  - op[1]=1 and ovf=1: result = {1'b0, all 1s} (max positive) when a[MSB]=0, else {1'b1, all 0s} (min negative).
  - ovf and carry are reported in every mode.
- Latency: out_valid rises exactly STAGES cycles after acceptance when out_ready stays 1. Throughput is one transfer per cycle.
- Backpressure: while out_valid && !out_ready, out_result, out_carry and out_ovf are held stable, in_ready=0, and no data is lost or reordered.
- Simultaneous accept and drain with adv=1 in the same cycle is allowed; the pipe stays full.
- Empty pipe: out_valid=0 and in_ready=1. Output data values are don't-care but retain the last registered values.
- STAGES=1 (SEG=WIDTH) is legal and gives single-cycle latency.

Test Plan (WIDTH=8, LANES=4, SEG=4, latency 2):
1. op 00, lane0 a=0x0F b=0x01, other lanes 0 -> two cycles later out_valid=1, lane0 result 0x10, carry 0, ovf 0. The mid-byte carry crosses the segment boundary.
2. op 00, lane1 a=0xFF b=0x01 and lane2 a=0x7F b=0x01 -> lane1 result 0x00, carry 1, ovf 0; lane2 result 0x80, carry 0, ovf 1; lanes 0 and 3 unaffected, proving no inter-lane carry.
3. op 01, lane0 a=0x05 b=0x07 and lane3 a=0x80 b=0x01 -> lane0 result 0xFE, carry 0; lane3 result 0x7F, carry 1, ovf 1.
4. op 10 with a=0x7F b=0x01 -> result 0x7F, ovf 1. op 11 with a=0x80 b=0x01 -> result 0x80, ovf 1. op 10 with a=0x10 b=0x20 -> result 0x30, ovf 0.
5. Four back-to-back transfers, then hold out_ready=0 once out_valid rises -> outputs stable, in_ready=0. Release out_ready -> all four results appear in order, one per cycle, none duplicated.
6. Assert rst_n=0 for one cycle with two transfers in flight -> out_valid drops immediately and all outputs read 0. After release, no stale results emerge, and a new transfer returns a correct result after two cycles.
